// File: rtl/tl_sensor_queue.sv
// Intersection model for the left-turn light controller: four lane queues fed by
// arrival detectors, drained while served, producing the Ta/Tal/Tb/Tbl sensors.
module tl_sensor_queue #(
    parameter int CNT_W      = 4,
    parameter int DEPART_CYC = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arr_a,
    input  logic             arr_al,
    input  logic             arr_b,
    input  logic             arr_bl,
    input  logic [1:0]       La,
    input  logic [1:0]       Lb,
    output logic             Ta,
    output logic             Tal,
    output logic             Tb,
    output logic             Tbl,
    output logic [CNT_W-1:0] qa,
    output logic [CNT_W-1:0] qal,
    output logic [CNT_W-1:0] qb,
    output logic [CNT_W-1:0] qbl,
    output logic             ovf,
    output logic             conflict
);

    localparam logic [CNT_W-1:0] MAX_Q    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_Q    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       TMR_LAST = 8'(DEPART_CYC - 1);
    localparam logic [1:0]       L_GREEN  = 2'b00;
    localparam logic [1:0]       L_RED    = 2'b10;
    localparam logic [1:0]       L_ARROW  = 2'b11;

    // Lane index order throughout: 0 = A straight, 1 = A left, 2 = B straight, 3 = B left.
    logic [3:0] arr_vec;
    logic [3:0] prev_reg;
    logic [3:0] rise;
    logic [3:0] serve;
    logic [3:0] busy;
    logic [3:0] depart;
    logic [3:0] ovf_hit;
    logic [1:0] road_last;
    logic       ovf_reg;
    logic       conflict_reg;

    assign arr_vec = {arr_bl, arr_b, arr_al, arr_a};
    assign rise    = arr_vec & ~prev_reg;
    assign serve   = {Lb == L_ARROW, Lb == L_GREEN, La == L_ARROW, La == L_GREEN};

    // One departure timer per road; only one lane of a road can be served at a time.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : road_g
            logic [7:0] tmr_reg;

            assign road_last[gi] = (tmr_reg == TMR_LAST);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tmr_reg <= 8'd0;
                end else if (busy[2*gi] || busy[2*gi+1]) begin
                    tmr_reg <= road_last[gi] ? 8'd0 : tmr_reg + 8'd1;
                end else begin
                    tmr_reg <= 8'd0;
                end
            end
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : lane_g
            logic [CNT_W-1:0] cnt_reg;

            assign busy[gi]    = serve[gi] && (cnt_reg != '0);
            assign depart[gi]  = busy[gi] && road_last[gi/2];
            assign ovf_hit[gi] = rise[gi] && !depart[gi] && (cnt_reg == MAX_Q);

            // A coincident arrival and departure cancel, even when saturated.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (rise[gi] && !depart[gi]) begin
                    if (cnt_reg != MAX_Q) begin
                        cnt_reg <= cnt_reg + ONE_Q;
                    end
                end else if (depart[gi] && !rise[gi]) begin
                    cnt_reg <= cnt_reg - ONE_Q;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_reg     <= 4'b0000;
            ovf_reg      <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            prev_reg <= arr_vec;
            if (|ovf_hit) begin
                ovf_reg <= 1'b1;
            end
            if ((La != L_RED) && (Lb != L_RED)) begin
                conflict_reg <= 1'b1;
            end
        end
    end

    assign qa       = lane_g[0].cnt_reg;
    assign qal      = lane_g[1].cnt_reg;
    assign qb       = lane_g[2].cnt_reg;
    assign qbl      = lane_g[3].cnt_reg;
    assign Ta       = (qa != '0);
    assign Tal      = (qal != '0);
    assign Tb       = (qb != '0);
    assign Tbl      = (qbl != '0);
    assign ovf      = ovf_reg;
    assign conflict = conflict_reg;

endmodule

// File: tb/tb_tl_sensor_queue.sv
// Table-driven bench for tl_sensor_queue with a scoreboard of expected states,
// plus hand sequences for reset behaviour (held reset, mid-drain reset, high-at-release).
module tb_tl_sensor_queue;

    localparam logic [1:0] GRN = 2'b00;
    localparam logic [1:0] RED = 2'b10;
    localparam logic [1:0] ARW = 2'b11;
    localparam logic [3:0] A   = 4'b0001;
    localparam logic [3:0] AL  = 4'b0010;
    localparam logic [3:0] BL  = 4'b1000;
    localparam logic [3:0] NO  = 4'b0000;

    logic       clk;
    logic       reset;
    logic       arr_a, arr_al, arr_b, arr_bl;
    logic [1:0] La, Lb;
    logic       Ta, Tal, Tb, Tbl;
    logic [3:0] qa, qal, qb, qbl;
    logic       ovf, conflict;

    tl_sensor_queue #(.CNT_W(4), .DEPART_CYC(3)) dut (
        .clk(clk), .reset(reset),
        .arr_a(arr_a), .arr_al(arr_al), .arr_b(arr_b), .arr_bl(arr_bl),
        .La(La), .Lb(Lb),
        .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
        .qa(qa), .qal(qal), .qb(qb), .qbl(qbl),
        .ovf(ovf), .conflict(conflict)
    );

    typedef struct {
        int   qa;
        int   qal;
        int   qb;
        int   qbl;
        logic ovf;
        logic conf;
    } exp_t;

    typedef struct {
        logic [3:0] arr;
        logic [1:0] la;
        logic [1:0] lb;
        exp_t       e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic add(input logic [3:0] arr, input logic [1:0] la, input logic [1:0] lb,
                       input int eqa, input int eqal, input int eqb, input int eqbl,
                       input logic eovf, input logic econf);
        vec_t v;
        v.arr = arr; v.la = la; v.lb = lb;
        v.e.qa = eqa; v.e.qal = eqal; v.e.qb = eqb; v.e.qbl = eqbl;
        v.e.ovf = eovf; v.e.conf = econf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        $display("%s: qa=%0d qal=%0d qb=%0d qbl=%0d T=%b%b%b%b ovf=%0b conflict=%0b",
                 tag, qa, qal, qb, qbl, Ta, Tal, Tb, Tbl, ovf, conflict);
        chk({tag, " qa"},  int'(qa),  e.qa);
        chk({tag, " qal"}, int'(qal), e.qal);
        chk({tag, " qb"},  int'(qb),  e.qb);
        chk({tag, " qbl"}, int'(qbl), e.qbl);
        chk({tag, " Ta"},  int'(Ta),  int'(e.qa != 0));
        chk({tag, " Tal"}, int'(Tal), int'(e.qal != 0));
        chk({tag, " Tb"},  int'(Tb),  int'(e.qb != 0));
        chk({tag, " Tbl"}, int'(Tbl), int'(e.qbl != 0));
        chk({tag, " ovf"}, int'(ovf), int'(e.ovf));
        chk({tag, " conflict"}, int'(conflict), int'(e.conf));
    endtask

    task automatic set_arr(input logic [3:0] arr);
        {arr_bl, arr_b, arr_al, arr_a} = arr;
    endtask

    function automatic exp_t mk(input int eqa, input int eqal, input int eqb, input int eqbl,
                                input logic eovf, input logic econf);
        exp_t e;
        e.qa = eqa; e.qal = eqal; e.qb = eqb; e.qbl = eqbl; e.ovf = eovf; e.conf = econf;
        return e;
    endfunction

    initial begin
        exp_t zero;
        exp_t got;
        int   drain_q[14];
        zero = mk(0, 0, 0, 0, 1'b0, 1'b0);
        drain_q = '{4, 4, 3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0};

        // Idle after reset release, then arrival counting with all lights red.
        add(NO, RED, RED, 0, 0, 0, 0, 0, 0);
        add(NO, RED, RED, 0, 0, 0, 0, 0, 0);
        add(A,  RED, RED, 1, 0, 0, 0, 0, 0);
        add(NO, RED, RED, 1, 0, 0, 0, 0, 0);
        add(A,  RED, RED, 2, 0, 0, 0, 0, 0);
        add(NO, RED, RED, 2, 0, 0, 0, 0, 0);
        add(A,  RED, RED, 3, 0, 0, 0, 0, 0);
        add(NO, RED, RED, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(A, RED, RED, 4, 0, 0, 0, 0, 0);
        add(NO, RED, RED, 4, 0, 0, 0, 0, 0);
        // Straight drain: one vehicle every third edge.
        for (int i = 0; i < 14; i++) add(NO, GRN, RED, drain_q[i], 0, 0, 0, 0, 0);
        // Build qa=2, qal=2.
        add(A | AL, RED, RED, 1, 1, 0, 0, 0, 0);
        add(NO,     RED, RED, 1, 1, 0, 0, 0, 0);
        add(A | AL, RED, RED, 2, 2, 0, 0, 0, 0);
        add(NO,     RED, RED, 2, 2, 0, 0, 0, 0);
        // Left arrow: only qal drains; arrival coincides with the edge-3 departure.
        add(NO, ARW, RED, 2, 2, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 2, 0, 0, 0, 0);
        add(AL, ARW, RED, 2, 2, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 2, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 2, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 1, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 1, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 1, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 0, 0, 0, 0, 0);
        add(NO, ARW, RED, 2, 0, 0, 0, 0, 0);
        // Saturation of qbl: the 16th pulse is dropped and sets ovf.
        for (int k = 1; k <= 16; k++) begin
            add(BL, RED, RED, 2, 0, 0, (k > 15) ? 15 : k, logic'(k == 16), 0);
            add(NO, RED, RED, 2, 0, 0, (k > 15) ? 15 : k, logic'(k == 16), 0);
        end
        for (int i = 0; i < 4; i++) add(NO, RED, GRN, 2, 0, 0, 15, 1, 0);
        // Conflicting commands for one edge, then qa drains with conflict held.
        add(NO, GRN, ARW, 2, 0, 0, 15, 1, 1);
        add(NO, GRN, RED, 2, 0, 0, 15, 1, 1);
        add(NO, GRN, RED, 1, 0, 0, 15, 1, 1);
        add(NO, GRN, RED, 1, 0, 0, 15, 1, 1);

        // Reset held with detectors toggling and conflicting greens.
        reset = 1'b1;
        set_arr(NO);
        La = GRN;
        Lb = GRN;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            set_arr(4'((c * 5) + 5));
            check_all($sformatf("reset[%0d]", c), zero);
        end
        set_arr(NO);
        La = RED;
        Lb = RED;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            set_arr(vecs[i].arr);
            La = vecs[i].la;
            Lb = vecs[i].lb;
            sb.push_back(vecs[i].e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            check_all($sformatf("vec[%0d] arr=%b La=%b Lb=%b", i, vecs[i].arr, vecs[i].la, vecs[i].lb),
                      got);
        end

        // Reset asserted between edges while qa is draining: must clear immediately.
        #2;
        reset = 1'b1;
        #1;
        check_all("mid_reset", zero);
        La = RED;
        Lb = RED;
        set_arr(4'b0100);
        @(posedge clk);
        #1;
        check_all("reset_hold_b_high", zero);
        reset = 1'b0;
        // A detector already high at release counts exactly once.
        sb.push_back(mk(0, 0, 1, 0, 1'b0, 1'b0));
        sb.push_back(mk(0, 0, 1, 0, 1'b0, 1'b0));
        sb.push_back(mk(0, 0, 1, 0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = sb.pop_front();
            check_all($sformatf("release_b_high[%0d]", i), got);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
